// File: rtl/rob_ring.sv
// Circular reorder buffer: in-order allocate/retire, out-of-order CDB writeback,
// operand lookup with same-cycle CDB forwarding and a synchronous full flush.
module rob_ring #(
  parameter int ROBID_BITS = 7,
  parameter int REGID_BITS = 5,
  parameter int VALUE_SIZE = 32,
  parameter int NUM_CDB    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  input  logic [REGID_BITS-1:0]         alloc_waddr,
  output logic                          alloc_ready,
  output logic [ROBID_BITS-1:0]         alloc_id,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*ROBID_BITS-1:0] cdb_id,
  input  logic [NUM_CDB*VALUE_SIZE-1:0] cdb_data,
  input  logic [ROBID_BITS-1:0]         robIDr1,
  input  logic [ROBID_BITS-1:0]         robIDr2,
  output logic [VALUE_SIZE-1:0]         src0,
  output logic [VALUE_SIZE-1:0]         src1,
  output logic                          src0_ready,
  output logic                          src1_ready,
  output logic                          commit_valid,
  output logic [REGID_BITS-1:0]         commit_waddr,
  output logic [VALUE_SIZE-1:0]         commit_wdata,
  input  logic                          commit_ready,
  input  logic                          flush,
  output logic [ROBID_BITS:0]           count,
  output logic                          full,
  output logic                          empty
);

  localparam int DEPTH = 1 << ROBID_BITS;
  localparam logic [ROBID_BITS:0] PTR_ONE = {{ROBID_BITS{1'b0}}, 1'b1};

  logic [ROBID_BITS:0]     head, tail;
  logic [ROBID_BITS-1:0]   head_idx, tail_idx;
  logic [DEPTH-1:0]        valid_q, done_q;
  logic [REGID_BITS-1:0]   waddr_q [DEPTH];
  logic [VALUE_SIZE-1:0]   value_q [DEPTH];
  logic [ROBID_BITS-1:0]   cdb_id_a   [NUM_CDB];
  logic [VALUE_SIZE-1:0]   cdb_data_a [NUM_CDB];
  logic                    alloc_fire, commit_fire;

  for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb_unpack
    assign cdb_id_a[g]   = cdb_id[g*ROBID_BITS +: ROBID_BITS];
    assign cdb_data_a[g] = cdb_data[g*VALUE_SIZE +: VALUE_SIZE];
  end

  assign head_idx    = head[ROBID_BITS-1:0];
  assign tail_idx    = tail[ROBID_BITS-1:0];
  assign empty       = (head == tail);
  assign full        = (head_idx == tail_idx) && (head[ROBID_BITS] != tail[ROBID_BITS]);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign alloc_id    = tail_idx;

  assign commit_valid = valid_q[head_idx] && done_q[head_idx];
  assign commit_waddr = valid_q[head_idx] ? waddr_q[head_idx] : '0;
  assign commit_wdata = valid_q[head_idx] ? value_q[head_idx] : '0;

  assign alloc_fire  = alloc_valid && !full;
  assign commit_fire = commit_valid && commit_ready;

  // Lookups see a CDB result in the same cycle it is broadcast; later buses win.
  always_comb begin
    src0       = valid_q[robIDr1] ? value_q[robIDr1] : '0;
    src0_ready = valid_q[robIDr1] && done_q[robIDr1];
    src1       = valid_q[robIDr2] ? value_q[robIDr2] : '0;
    src1_ready = valid_q[robIDr2] && done_q[robIDr2];
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && valid_q[robIDr1] && (cdb_id_a[k] == robIDr1)) begin
        src0       = cdb_data_a[k];
        src0_ready = 1'b1;
      end
      if (cdb_valid[k] && valid_q[robIDr2] && (cdb_id_a[k] == robIDr2)) begin
        src1       = cdb_data_a[k];
        src1_ready = 1'b1;
      end
    end
  end

  // Commit and allocate never touch the same slot: that needs full (alloc blocked) or empty (no commit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_valid[k] && valid_q[cdb_id_a[k]]) begin
          done_q[cdb_id_a[k]] <= 1'b1;
        end
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        head              <= head + PTR_ONE;
      end
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        tail              <= tail + PTR_ONE;
      end
    end
  end

  // Payload storage is not reset; every read of it is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (cdb_valid[k] && valid_q[cdb_id_a[k]]) begin
          value_q[cdb_id_a[k]] <= cdb_data_a[k];
        end
      end
      if (alloc_fire) begin
        waddr_q[tail_idx] <= alloc_waddr;
      end
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// Self-checking bench for rob_ring (depth 8, two CDBs): directed scenarios plus
// randomized traffic compared against a sequence-number based reference model.
module tb_rob_ring;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_waddr;
  logic        alloc_ready;
  logic [2:0]  alloc_id;
  logic [1:0]  cdb_valid;
  logic [5:0]  cdb_id;
  logic [63:0] cdb_data;
  logic [2:0]  robIDr1, robIDr2;
  logic [31:0] src0, src1;
  logic        src0_ready, src1_ready;
  logic        commit_valid;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_wdata;
  logic        commit_ready;
  logic        flush;
  logic [3:0]  count;
  logic        full, empty;

  int total = 0;
  int bad   = 0;

  // Reference model: absolute sequence numbers for head/tail, slot = seq % 8.
  int          m_head, m_tail;
  bit          m_valid [8];
  bit          m_done  [8];
  logic [4:0]  m_waddr [8];
  logic [31:0] m_value [8];

  rob_ring #(.ROBID_BITS(3), .REGID_BITS(5), .VALUE_SIZE(32), .NUM_CDB(2)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_waddr(alloc_waddr),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .robIDr1(robIDr1), .robIDr2(robIDr2),
    .src0(src0), .src1(src1), .src0_ready(src0_ready), .src1_ready(src1_ready),
    .commit_valid(commit_valid), .commit_waddr(commit_waddr),
    .commit_wdata(commit_wdata), .commit_ready(commit_ready),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_head = 0;
    m_tail = 0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int  cnt, hi, ti;
    bit  pre_valid [8];
    bit  cfire, afire;
    logic [2:0] id;
    if (rst || flush) begin
      model_reset();
      return;
    end
    cnt = m_tail - m_head;
    hi = m_head % 8;
    ti = m_tail % 8;
    pre_valid = m_valid;
    cfire = m_valid[hi] && m_done[hi] && commit_ready;
    afire = alloc_valid && (cnt < 8);
    for (int k = 0; k < 2; k++) begin
      id = cdb_id[k*3 +: 3];
      if (cdb_valid[k] && pre_valid[id]) begin
        m_value[id] = cdb_data[k*32 +: 32];
        m_done[id]  = 1'b1;
      end
    end
    if (cfire) begin
      m_valid[hi] = 1'b0;
      m_head++;
    end
    if (afire) begin
      m_valid[ti] = 1'b1;
      m_done[ti]  = 1'b0;
      m_waddr[ti] = alloc_waddr;
      m_tail++;
    end
  endtask

  // known=0 when the slot is valid but never written, so its value is undefined.
  task automatic model_lookup(input logic [2:0] id, output logic [31:0] v,
                              output bit rdy, output bit known);
    v     = m_valid[id] ? m_value[id] : 32'd0;
    rdy   = m_valid[id] && m_done[id];
    known = !m_valid[id] || m_done[id];
    for (int k = 0; k < 2; k++) begin
      if (cdb_valid[k] && m_valid[id] && (cdb_id[k*3 +: 3] == id)) begin
        v     = cdb_data[k*32 +: 32];
        rdy   = 1'b1;
        known = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid  = 1'b0;
    alloc_waddr  = '0;
    cdb_valid    = '0;
    cdb_id       = '0;
    cdb_data     = '0;
    commit_ready = 1'b0;
    flush        = 1'b0;
    robIDr1      = '0;
    robIDr2      = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_alloc_ready got=%b want=1", alloc_ready); end
    total++; if (alloc_id !== 3'd0) begin bad++; $display("[TB] FAIL reset_alloc_id got=%0d want=0", alloc_id); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if (commit_valid !== 1'b0 || commit_wdata !== 32'd0 || commit_waddr !== 5'd0) begin bad++; $display("[TB] FAIL reset_commit got v=%b a=%0d d=%h want 0", commit_valid, commit_waddr, commit_wdata); end
    total++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0 || src0 !== 32'd0) begin bad++; $display("[TB] FAIL reset_src got r0=%b r1=%b s0=%h want 0", src0_ready, src1_ready, src0); end
    @(negedge clk);
    cycle();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_waddr = 5'(i + 1);
      #1;
      total++; if (alloc_id !== 3'(i) || alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_id got id=%0d rdy=%b want id=%0d rdy=1", alloc_id, alloc_ready, i); end
      cycle();
    end
    alloc_waddr = 5'd9;
    #1;
    total++; if (full !== 1'b1 || count !== 4'd8 || alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_full got full=%b count=%0d rdy=%b want 1/8/0", full, count, alloc_ready); end
    cycle();
    alloc_valid = 1'b0;
    #1;
    total++; if (count !== 4'd8 || alloc_id !== 3'd0) begin bad++; $display("[TB] FAIL fill_ignored got count=%0d id=%0d want 8/0", count, alloc_id); end
  endtask

  task automatic test_cdb_order();
    commit_ready = 1'b1;
    cdb_valid = 2'b01; cdb_id[2:0] = 3'd2; cdb_data[31:0] = 32'h20;
    #1;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("[TB] FAIL order_wait0 got=%b want=0", commit_valid); end
    cycle();
    cdb_id[2:0] = 3'd0; cdb_data[31:0] = 32'h00;
    #1;
    total++; if (commit_valid !== 1'b0) begin bad++; $display("[TB] FAIL order_no_bypass got=%b want=0", commit_valid); end
    cycle();
    cdb_id[2:0] = 3'd1; cdb_data[31:0] = 32'h10;
    #1;
    total++; if (commit_valid !== 1'b1 || commit_waddr !== 5'd1 || commit_wdata !== 32'h0) begin bad++; $display("[TB] FAIL order_c0 got v=%b a=%0d d=%h want 1/1/0", commit_valid, commit_waddr, commit_wdata); end
    cycle();
    cdb_valid = 2'b00;
    #1;
    total++; if (commit_valid !== 1'b1 || commit_waddr !== 5'd2 || commit_wdata !== 32'h10) begin bad++; $display("[TB] FAIL order_c1 got v=%b a=%0d d=%h want 1/2/10", commit_valid, commit_waddr, commit_wdata); end
    cycle();
    #1;
    total++; if (commit_valid !== 1'b1 || commit_waddr !== 5'd3 || commit_wdata !== 32'h20) begin bad++; $display("[TB] FAIL order_c2 got v=%b a=%0d d=%h want 1/3/20", commit_valid, commit_waddr, commit_wdata); end
    cycle();
    commit_ready = 1'b0;
    #1;
    total++; if (count !== 4'd5 || commit_valid !== 1'b0) begin bad++; $display("[TB] FAIL order_after got count=%0d v=%b want 5/0", count, commit_valid); end
  endtask

  task automatic test_full_laps();
    int h;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_waddr = 5'(20 + i);
      cycle();
    end
    h = 3;
    for (int n = 0; n < 24; n++) begin
      alloc_valid = 1'b1; commit_ready = 1'b0;
      cdb_valid = 2'b01; cdb_id[2:0] = 3'(h); cdb_data[31:0] = $urandom;
      #1;
      total++; if (full !== 1'b1 || empty !== 1'b0 || alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL lap_full n=%0d got full=%b empty=%b rdy=%b want 1/0/0", n, full, empty, alloc_ready); end
      cycle();
      cdb_valid = 2'b00; commit_ready = 1'b1; alloc_waddr = 5'($urandom);
      #1;
      total++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0) begin bad++; $display("[TB] FAIL lap_commit_blocks n=%0d got cv=%b rdy=%b want 1/0", n, commit_valid, alloc_ready); end
      cycle();
      commit_ready = 1'b0;
      #1;
      total++; if (count !== 4'd7 || alloc_id !== 3'(h) || alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL lap_refill n=%0d got count=%0d id=%0d rdy=%b want 7/%0d/1", n, count, alloc_id, alloc_ready, h); end
      cycle();
      h = (h + 1) % 8;
    end
    idle();
    #1;
    total++; if (full !== 1'b1 || count !== 4'd8 || alloc_id !== 3'd3) begin bad++; $display("[TB] FAIL lap_end got full=%b count=%0d id=%0d want 1/8/3", full, count, alloc_id); end
  endtask

  task automatic test_dual_cdb();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_waddr = 5'(10 + i);
      cycle();
    end
    alloc_valid = 1'b0;
    cdb_valid = 2'b11; cdb_id = {3'd4, 3'd4}; cdb_data = {32'hB, 32'hA};
    robIDr1 = 3'd4; robIDr2 = 3'd3;
    #1;
    total++; if (src0 !== 32'hB || src0_ready !== 1'b1) begin bad++; $display("[TB] FAIL dual_forward got s0=%h r=%b want b/1", src0, src0_ready); end
    cycle();
    cdb_valid = 2'b00;
    #1;
    total++; if (src0 !== 32'hB || src0_ready !== 1'b1) begin bad++; $display("[TB] FAIL dual_stored got s0=%h r=%b want b/1", src0, src0_ready); end
    total++; if (src1_ready !== 1'b0 || commit_valid !== 1'b0) begin bad++; $display("[TB] FAIL dual_others got r1=%b cv=%b want 0/0", src1_ready, commit_valid); end
  endtask

  task automatic test_stall();
    cdb_valid = 2'b10; cdb_id[5:3] = 3'd0; cdb_data[63:32] = 32'h55;
    cycle();
    cdb_valid = 2'b00; commit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (commit_valid !== 1'b1 || count !== 4'd5 || commit_wdata !== 32'h55) begin bad++; $display("[TB] FAIL stall_hold i=%0d got cv=%b count=%0d d=%h want 1/5/55", i, commit_valid, count, commit_wdata); end
      cycle();
    end
    commit_ready = 1'b1;
    cycle();
    commit_ready = 1'b0;
    #1;
    total++; if (count !== 4'd4 || commit_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_release got count=%0d cv=%b want 4/0", count, commit_valid); end
  endtask

  task automatic test_flush();
    alloc_valid = 1'b1; alloc_waddr = 5'd20;
    cycle();
    flush = 1'b1; alloc_valid = 1'b1; commit_ready = 1'b1;
    cdb_valid = 2'b01; cdb_id[2:0] = 3'd2; cdb_data[31:0] = 32'h77;
    cycle();
    idle();
    robIDr1 = 3'd2;
    #1;
    total++; if (empty !== 1'b1 || count !== 4'd0 || alloc_id !== 3'd0) begin bad++; $display("[TB] FAIL flush_ptrs got empty=%b count=%0d id=%0d want 1/0/0", empty, count, alloc_id); end
    total++; if (commit_valid !== 1'b0 || src0_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_entries got cv=%b r0=%b want 0/0", commit_valid, src0_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_waddr = 5'(i + 1);
      cycle();
    end
    alloc_valid = 1'b0;
    cdb_valid = 2'b01; cdb_id[2:0] = 3'd0; cdb_data[31:0] = 32'h99;
    cycle();
    idle();
    #1;
    total++; if (commit_valid !== 1'b1 || count !== 4'd3) begin bad++; $display("[TB] FAIL mid_before got cv=%b count=%0d want 1/3", commit_valid, count); end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1 || alloc_id !== 3'd0 || commit_valid !== 1'b0 || alloc_ready !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL mid_async got count=%0d empty=%b id=%0d cv=%b rdy=%b full=%b", count, empty, alloc_id, commit_valid, alloc_ready, full); end
    cycle();
    rst = 1'b0;
    commit_ready = 1'b1;
    cycle();
    #1;
    total++; if (commit_valid !== 1'b0 || count !== 4'd0) begin bad++; $display("[TB] FAIL mid_after got cv=%b count=%0d want 0/0", commit_valid, count); end
    idle();
  endtask

  task automatic test_random();
    int cnt, hi;
    logic [31:0] e_s0, e_s1;
    bit e_r0, e_r1, k0, k1;
    for (int n = 0; n < 600; n++) begin
      cnt = m_tail - m_head;
      alloc_valid  = ($urandom_range(9) < 6);
      alloc_waddr  = 5'($urandom);
      commit_ready = ($urandom_range(9) < 7);
      flush        = ($urandom_range(59) == 0);
      for (int k = 0; k < 2; k++) begin
        cdb_valid[k] = $urandom_range(1);
        if (cnt > 0 && $urandom_range(3) != 0)
          cdb_id[k*3 +: 3] = 3'((m_head + $urandom_range(cnt - 1)) % 8);
        else
          cdb_id[k*3 +: 3] = 3'($urandom);
        cdb_data[k*32 +: 32] = $urandom;
      end
      robIDr1 = 3'($urandom);
      robIDr2 = ($urandom_range(1) == 1) ? cdb_id[2:0] : 3'($urandom);
      #1;
      hi = m_head % 8;
      model_lookup(robIDr1, e_s0, e_r0, k0);
      model_lookup(robIDr2, e_s1, e_r1, k1);
      total++; if (count !== 4'(cnt)) begin bad++; $display("[TB] FAIL rnd_count n=%0d got=%0d want=%0d", n, count, cnt); end
      total++; if (full !== (cnt == 8) || empty !== (cnt == 0) || alloc_ready !== (cnt != 8)) begin bad++; $display("[TB] FAIL rnd_flags n=%0d got full=%b empty=%b rdy=%b cnt=%0d", n, full, empty, alloc_ready, cnt); end
      total++; if (alloc_id !== 3'(m_tail % 8)) begin bad++; $display("[TB] FAIL rnd_alloc_id n=%0d got=%0d want=%0d", n, alloc_id, m_tail % 8); end
      total++; if (commit_valid !== (m_valid[hi] && m_done[hi])) begin bad++; $display("[TB] FAIL rnd_commit_valid n=%0d got=%b", n, commit_valid); end
      if (m_valid[hi] && m_done[hi]) begin
        total++; if (commit_waddr !== m_waddr[hi] || commit_wdata !== m_value[hi]) begin bad++; $display("[TB] FAIL rnd_commit_data n=%0d got a=%0d d=%h want a=%0d d=%h", n, commit_waddr, commit_wdata, m_waddr[hi], m_value[hi]); end
      end
      total++; if (src0_ready !== e_r0 || src1_ready !== e_r1) begin bad++; $display("[TB] FAIL rnd_src_ready n=%0d got %b/%b want %b/%b", n, src0_ready, src1_ready, e_r0, e_r1); end
      if (k0) begin
        total++; if (src0 !== e_s0) begin bad++; $display("[TB] FAIL rnd_src0 n=%0d got=%h want=%h", n, src0, e_s0); end
      end
      if (k1) begin
        total++; if (src1 !== e_s1) begin bad++; $display("[TB] FAIL rnd_src1 n=%0d got=%h want=%h", n, src1, e_s1); end
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_cdb_order();
    test_full_laps();
    test_dual_cdb();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_ring.md
Name: rob_ring

Overview:
- Parametrised circular reorder buffer.
- Allocates entries in program order at dispatch and accepts out-of-order results from NUM_CDB common data buses.
- Retires completed entries strictly in order to the RAT/register file, one per cycle, under a valid/ready handshake.
- Supports read-by-ID for operand fetch with same-cycle CDB forwarding, plus a full pipeline flush.

Parameters:
- ROBID_BITS, 7, entry index width; depth = 2**ROBID_BITS.
- REGID_BITS, 5, architectural destination register index width.
- VALUE_SIZE, 32, result data width.
- NUM_CDB, 2, number of independent result-writeback buses.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc_valid  input  1  dispatch requests an entry this cycle.
- alloc_waddr  input  REGID_BITS  destination register of the dispatching instruction.
- alloc_ready  output  1  equals !full; allocation occurs when alloc_valid && alloc_ready.
- alloc_id  output  ROBID_BITS  tail index; the ID assigned if allocation occurs this cycle.
- cdb_valid  input  NUM_CDB  per-bus result valid.
- cdb_id  input  NUM_CDB*ROBID_BITS  per-bus target entry; bus k occupies bits [k*ROBID_BITS +: ROBID_BITS].
- cdb_data  input  NUM_CDB*VALUE_SIZE  per-bus result value, same packing.
- robIDr1, robIDr2  input  ROBID_BITS  operand lookup IDs.
- src0, src1  output  VALUE_SIZE  lookup values.
- src0_ready, src1_ready  output  1  lookup entry is valid and its value is available.
- commit_valid  output  1  head entry is valid and done.
- commit_waddr  output  REGID_BITS  head destination register.
- commit_wdata  output  VALUE_SIZE  head result value.
- commit_ready  input  1  RAT accepts the commit this cycle.
- flush  input  1  synchronous squash of all entries.
- count  output  ROBID_BITS+1  occupied entries, range 0..2**ROBID_BITS.
- full, empty  output  1  count == depth, count == 0.

Behaviour:
- Entry contents: valid, done, waddr[REGID_BITS], value[VALUE_SIZE].
- Pointers: head and tail are each ROBID_BITS+1 bits; the MSB is a wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
  - count = tail - head, modulo 2**(ROBID_BITS+1).
- Reset (async, rst=1):
  - head = tail = 0; all valid and done bits = 0.
  - Outputs settle to: alloc_ready=1, alloc_id=0, empty=1, full=0, count=0, commit_valid=0, src*_ready=0.
  - commit_wdata, commit_waddr, src0 and src1 read as 0 while the entry is invalid. These outputs are gated by valid.
  - Reset asserted mid-operation discards all state; no commit is issued after it.
- Allocation:
  - On the edge where alloc_valid && !full: entry[tail] gets valid=1, done=0, waddr=alloc_waddr; tail increments.
  - alloc_valid while full is ignored with no state change.
- CDB writeback:
  - On the edge where cdb_valid[k] is high and entry[cdb_id_k].valid is set: value is written and done is set.
  - A write to an invalid entry is dropped.
  - Two buses naming the same ID in one cycle: the highest k wins.
  - A CDB write to the entry being allocated in the same cycle is dropped; that entry is not valid before the edge.
- Commit:
  - commit_* outputs are combinational from entry[head].
  - commit_valid = valid && done.
  - On the edge where commit_valid && commit_ready: entry[head].valid is cleared and head increments.
  - A result written by the CDB at edge N is committable in the cycle after N (latency 1). There is no CDB-to-commit bypass.
  - Commit stalls indefinitely while commit_ready=0; state holds.
- Simultaneous alloc and commit:
  - Both proceed and count is unchanged.
  - When full, allocation is blocked even if a commit occurs the same cycle; the full flag uses pre-edge state.
  - When empty, no commit is possible.
- Lookup (combinational):
  - srcN = entry[id].value and srcN_ready = valid && done.
  - Forwarding: if a CDB bus in the same cycle targets a valid entry with that id, srcN takes that bus's data (highest k wins) and srcN_ready=1.
- Wrap-around: indexes roll from 2**ROBID_BITS-1 to 0 and the wrap bit toggles; no bubble at the wrap.
- Flush:
  - On the edge with flush=1, all valid bits clear and head = tail = 0.
  - Flush takes priority over allocation, CDB writes and commit in that cycle; none of them take effect.

Test Plan:
- ROBID_BITS=3: reset, then allocate 8 entries with waddr 1..8 -> alloc_id runs 0..7; full=1 and count=8 after the 8th; a 9th alloc_valid is ignored and tail is unchanged.
- CDB writes ids 2,0,1 with data 0x20,0x00,0x10 on separate cycles; commit_ready=1 -> commits occur in order id0 (waddr1,0x0), id1 (waddr2,0x10), id2 (waddr3,0x20); each commit lands one cycle after the later of its own done and the prior commit.
- Full buffer: commit one entry and drive alloc_valid the same cycle -> alloc blocked; the next cycle alloc is accepted with alloc_id equal to the freed index; continue until the index wraps 7->0 and confirm full/empty flags across 3 full laps.
- Both CDB buses target id 4 with data 0xA and 0xB -> entry 4 holds 0xB; robIDr1=4 in that cycle -> src0=0xB and src0_ready=1.
- commit_ready held 0 for 5 cycles with the head done -> commit_valid stays 1 and head/count are unchanged; raise commit_ready -> a single commit occurs.
- 5 entries in flight, assert flush together with alloc_valid and cdb_valid -> next cycle empty=1, count=0, alloc_id=0, commit_valid=0; assert rst mid-sequence -> outputs return to reset values asynchronously.
